regbank_dump_reader: RTL and testbench



---
 rtl/regbank_dump_reader.sv | 154 +++++++++++++++
 tb/tb_regbank_dump_reader.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_dump_reader.sv
// regbank_dump_reader: walks the register bank display port over
// [FIRST_REG..LAST_REG] and streams each word out on valid/ready.
// Optional build macro REGDUMP_SKIP_ZERO_EN: zero-valued registers
// are scanned but not presented.
// Ports:
//   iCLK, iCLR          clock, synchronous active-high reset
//   iStart, iAbort      dump request (IDLE only), cancel dump
//   oRegDispSelect      index driven to the bank display select
//   iRegDisp            bank display data for oRegDispSelect
//   oData, oIndex       captured word and its register index
//   oValid, iReady      output handshake
//   oBusy, oDone        not-idle flag, end-of-dump pulse
//   oWordCount          words accepted in current/last dump
module regbank_dump_reader #(
    parameter int DATA_W    = 64,
    parameter int SEL_W     = 5,
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              iCLK,
    input  logic              iCLR,
    input  logic              iStart,
    input  logic              iAbort,
    output logic [SEL_W-1:0]  oRegDispSelect,
    input  logic [DATA_W-1:0] iRegDisp,
    output logic [DATA_W-1:0] oData,
    output logic [SEL_W-1:0]  oIndex,
    output logic              oValid,
    input  logic              iReady,
    output logic              oBusy,
    output logic              oDone,
    output logic [SEL_W:0]    oWordCount
);

    generate
        if (FIRST_REG < 0 || FIRST_REG > LAST_REG ||
            LAST_REG > (2**SEL_W) - 1) begin : g_bad_range
            $error("regbank_dump_reader: illegal FIRST_REG/LAST_REG");
        end
    endgenerate

    localparam logic [SEL_W-1:0] L_FIRST = SEL_W'(FIRST_REG);
    localparam logic [SEL_W-1:0] L_LAST  = SEL_W'(LAST_REG);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_SEND,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [SEL_W-1:0]    r_idx;
    logic [SEL_W-1:0]    w_idx_nxt;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   w_data_nxt;
    logic [SEL_W-1:0]    r_index;
    logic [SEL_W-1:0]    w_index_nxt;
    logic [SEL_W:0]      r_cnt;
    logic [SEL_W:0]      w_cnt_nxt;
    logic                w_last;

    // idx stops at LAST_REG, so the increment can never wrap
    assign w_last = (r_idx == L_LAST);

    always_ff @(posedge iCLK) begin
        if (iCLR) begin
            r_state <= S_IDLE;
            r_idx   <= L_FIRST;
            r_data  <= '0;
            r_index <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_index <= w_index_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_index_nxt = r_index;
        w_cnt_nxt   = r_cnt;
        oValid      = 1'b0;
        oBusy       = (r_state != S_IDLE);
        oDone       = 1'b0;
        if (iAbort && r_state != S_IDLE) begin
            // abort wins over acceptance and suppresses the done pulse
            w_state_nxt = S_IDLE;
            w_idx_nxt   = L_FIRST;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (iStart && !iAbort) begin
                        w_idx_nxt   = L_FIRST;
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_FETCH;
                    end
                end
                S_FETCH: begin
`ifdef REGDUMP_SKIP_ZERO_EN
                    if (iRegDisp == '0) begin
                        if (w_last) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_idx_nxt = r_idx + 1'b1;
                        end
                    end else begin
                        w_data_nxt  = iRegDisp;
                        w_index_nxt = r_idx;
                        w_state_nxt = S_SEND;
                    end
`else
                    w_data_nxt  = iRegDisp;
                    w_index_nxt = r_idx;
                    w_state_nxt = S_SEND;
`endif
                end
                S_SEND: begin
                    oValid = 1'b1;
                    if (iReady) begin
                        w_cnt_nxt = r_cnt + 1'b1;
                        if (w_last) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_idx_nxt   = r_idx + 1'b1;
                            w_state_nxt = S_FETCH;
                        end
                    end
                end
                S_DONE: begin
                    oDone       = 1'b1;
                    w_idx_nxt   = L_FIRST;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_idx_nxt   = L_FIRST;
                end
            endcase
        end
    end

    assign oRegDispSelect = r_idx;
    assign oData          = r_data;
    assign oIndex         = r_index;
    assign oWordCount     = r_cnt;

endmodule

// File: tb/tb_regbank_dump_reader.sv
// Bench for regbank_dump_reader: random and directed dumps checked
// against a word-list reference model built from the bank contents.
module tb_regbank_dump_reader;

`ifdef REGDUMP_SKIP_ZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        clr, start, abort, ready, start1;
    logic [4:0]  sel, index, sel1, index1;
    logic [63:0] rdisp, data, rdisp1, data1;
    logic        valid, busy, done, valid1, busy1, done1;
    logic [5:0]  wcnt, wcnt1;
    logic [63:0] bank [0:31];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign rdisp  = bank[sel];
    assign rdisp1 = bank[sel1];

    regbank_dump_reader u_dut (
        .iCLK(clk), .iCLR(clr), .iStart(start), .iAbort(abort),
        .oRegDispSelect(sel), .iRegDisp(rdisp), .oData(data),
        .oIndex(index), .oValid(valid), .iReady(ready),
        .oBusy(busy), .oDone(done), .oWordCount(wcnt)
    );

    regbank_dump_reader #(.FIRST_REG(31), .LAST_REG(31)) u_dut1 (
        .iCLK(clk), .iCLR(clr), .iStart(start1), .iAbort(abort),
        .oRegDispSelect(sel1), .iRegDisp(rdisp1), .oData(data1),
        .oIndex(index1), .oValid(valid1), .iReady(ready),
        .oBusy(busy1), .oDone(done1), .oWordCount(wcnt1)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: the dump is the ordered list of range registers
    // (non-zero only when skipping), valued as at dump start.
    task automatic dump(input int rdy_pct, input int bp_idx,
                        input int abort_idx);
        int          q_idx[$];
        logic [63:0] q_val[$];
        int cyc, acc, nw, first_cyc, done_cyc, hold;
        bit all_ready;
        for (int i = 0; i < 32; i++) begin
            if (!SKIP || bank[i] != 64'd0) begin
                q_idx.push_back(i);
                q_val.push_back(bank[i]);
            end
        end
        nw = q_idx.size();
        all_ready = (rdy_pct >= 100) && (bp_idx < 0);
        abort = 1'b0;
        ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_cnt", wcnt, 0);
        chk("start_valid", valid, 0);
        cyc = 1;
        acc = 0;
        first_cyc = -1;
        done_cyc = -1;
        hold = 0;
        while (done_cyc < 0 && cyc < 400) begin
            ready = ($urandom_range(99) < rdy_pct);
            if (valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                chk("word_avail", acc < nw, 1);
                if (acc < nw) begin
                    chk("index", index, q_idx[acc]);
                    chk("data", data, q_val[acc]);
                end
                if (bp_idx >= 0 && index == bp_idx && hold < 5) begin
                    ready = 1'b0;
                    if (hold == 0) bank[bp_idx] = 64'hDEAD;
                    hold++;
                end
                if (abort_idx >= 0 && index == abort_idx) begin
                    abort = 1'b1;
                    step();
                    abort = 1'b0;
                    chk("abort_valid", valid, 0);
                    chk("abort_busy", busy, 0);
                    chk("abort_done", done, 0);
                    chk("abort_cnt", wcnt, acc);
                    step();
                    chk("abort_nodone", done, 0);
                    return;
                end
                if (ready) acc++;
            end
            if (done) begin
                done_cyc = cyc;
                chk("done_cnt", wcnt, nw);
            end
            step();
            cyc++;
        end
        chk("done_seen", done_cyc >= 0, 1);
        chk("words", acc, nw);
        chk("hold_cnt", wcnt, nw);
        chk("done_once", done, 0);
        chk("idle", busy, 0);
        chk("sel_rewind", sel, 0);
        if (all_ready) begin
            chk("first_lat", first_cyc, nw > 0 ? q_idx[0] + 2 : -1);
            chk("done_lat", done_cyc, 32 + nw + 1);
        end
    endtask

    initial begin
        int guard;
        clr = 1'b1;
        start = 1'b0;
        start1 = 1'b0;
        abort = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 32; i++) bank[i] = 64'd0;
        bank[28] = 64'h7fffeffc;
        step();
        step();
        chk("rst_data", data, 0);
        chk("rst_index", index, 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", wcnt, 0);
        chk("rst_sel", sel, 0);
        chk("rst_sel1", sel1, 31);
        clr = 1'b0;
        step();

        dump(100, -1, -1);
        dump(100, 4, -1);
        dump(100, -1, 10);
        dump(100, -1, -1);

        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_start_idle", busy, 0);
        step();
        chk("abort_start_idle2", busy, 0);

        ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (!(busy && !valid && sel == 5'd7) && guard < 100) begin
            step();
            guard++;
        end
        chk("reach_fetch7", guard < 100, 1);
        clr = 1'b1;
        start = 1'b1;
        step();
        clr = 1'b0;
        start = 1'b0;
        chk("mid_rst_data", data, 0);
        chk("mid_rst_index", index, 0);
        chk("mid_rst_valid", valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_cnt", wcnt, 0);
        chk("mid_rst_sel", sel, 0);
        step();
        chk("rst_start_ignored", busy, 0);

        bank[31] = {$urandom, $urandom} | 64'd1;
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("b1_busy", busy1, 1);
        chk("b1_fetch_valid", valid1, 0);
        step();
        chk("b1_valid", valid1, 1);
        chk("b1_index", index1, 31);
        chk("b1_data", data1, bank[31]);
        start1 = 1'b1;
        step();
        start1 = 1'b0;
        chk("b1_done", done1, 1);
        chk("b1_cnt", wcnt1, 1);
        chk("b1_novalid", valid1, 0);
        step();
        chk("b1_done_once", done1, 0);
        chk("b1_idle", busy1, 0);
        step();
        chk("b1_no_second", busy1, 0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 32; i++) begin
                bank[i] = ($urandom_range(2) == 0) ? 64'd0
                                                   : {$urandom, $urandom};
            end
            dump($urandom_range(90, 30), -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
